axilite_uart_slave: RTL and testbench

AXI4-Lite responder that terminates writes and reads from the picorv32 AXI4-Lite master inside `pico_axilite_top` and turns them into an 8N1 UART console. It contains a 4-deep TX byte FIFO with a serializer, an RX deserializer with a single-byte holding register, and a runtime baud divider. It drives the top-level `tx` pin and samples the top-level `rx` pin.

---
 rtl/axilite_uart_slave.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_axilite_uart_slave.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axilite_uart_slave.sv
// axilite_uart_slave
//   AXI4-Lite responder that exposes an 8N1 UART console to the picorv32 master.
//   It contains a TX byte FIFO that feeds a serializer, an RX deserializer with a
//   single-byte holding register, and a baud divider that can be changed at runtime.
//
// Register map (byte address, bits [3:2] select the register):
//   0x0 TXDATA (W)  push wdata[7:0] when wstrb[0]; SLVERR if the FIFO is full
//   0x4 STATUS (R)  {rx_overrun, rx_valid, tx_idle, tx_full}; a read clears rx_overrun
//   0x8 RXDATA (R)  rx_data[7:0]; a read clears rx_valid
//   0xC DIV    (RW) clocks per bit, [15:0]; values below 4 are stored as 4
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_axi_aw* / s_axi_w* / s_axi_b*  write address, data and response channels
//   s_axi_ar* / s_axi_r*          read address and data channels
//   tx                            UART transmit (idle high)
//   rx                            UART receive (asynchronous)
module axilite_uart_slave #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [3:0]  s_axi_awaddr,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic [1:0]  s_axi_bresp,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [3:0]  s_axi_araddr,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        tx,
    input  logic        rx
);

    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [15:0] DIV_RST = 16'(CLK_DIV);

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Below 4 clocks per bit the half-bit start re-check and the bit timers
    // degenerate, so small divider values saturate to 4.
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < 16'd4) ? 16'd4 : v;
    endfunction

    logic [0:0]  wstate;
    logic [0:0]  rstate;
    logic [15:0] div_q;

    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;

    logic        tx_busy;
    logic [3:0]  tx_bitcnt;
    logic [15:0] tx_timer;
    logic [8:0]  tx_shift;

    logic [1:0]  rx_sync;
    logic        rx_prev;
    logic [1:0]  rx_state;
    logic [15:0] rx_timer;
    logic [2:0]  rx_bitcnt;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_overrun;

    logic        wr_hs;
    logic        rd_hs;
    logic [1:0]  wr_reg;
    logic [1:0]  rd_reg;
    logic        tx_full;
    logic        tx_idle;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        rx_s;
    logic        rx_done;
    logic        rd_status;
    logic        rd_rxdata;
    logic [15:0] div_wr;
    logic [31:0] rd_mux;

    logic unused_bits;
    assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0],
                           s_axi_wdata[31:16], s_axi_wstrb[3:2]};

    // ---------------- handshakes and decode ----------------
    assign wr_hs  = !rst && (wstate == W_IDLE) && s_axi_awvalid && s_axi_wvalid;
    assign rd_hs  = !rst && (rstate == R_IDLE) && s_axi_arvalid;
    assign s_axi_awready = wr_hs;
    assign s_axi_wready  = wr_hs;
    assign s_axi_arready = rd_hs;
    assign s_axi_rresp   = 2'b00;

    assign wr_reg    = s_axi_awaddr[3:2];
    assign rd_reg    = s_axi_araddr[3:2];
    assign tx_full   = (count == CW'(FIFO_DEPTH));
    assign tx_idle   = (count == '0) && !tx_busy;
    assign push_req  = wr_hs && (wr_reg == 2'd0) && s_axi_wstrb[0];
    assign push      = push_req && !tx_full;
    assign pop       = !tx_busy && (count != '0);
    assign rd_status = rd_hs && (rd_reg == 2'd1);
    assign rd_rxdata = rd_hs && (rd_reg == 2'd2);

    assign div_wr = {s_axi_wstrb[1] ? s_axi_wdata[15:8] : div_q[15:8],
                     s_axi_wstrb[0] ? s_axi_wdata[7:0]  : div_q[7:0]};

    // ---------------- write channel ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate       <= W_IDLE;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (wr_hs) begin
                        wstate       <= W_RESP;
                        s_axi_bvalid <= 1'b1;
                        // Only a TXDATA push that finds the FIFO full is refused.
                        s_axi_bresp  <= (push_req && tx_full) ? 2'b10 : 2'b00;
                    end
                end
                default: begin
                    if (s_axi_bready) begin
                        wstate       <= W_IDLE;
                        s_axi_bvalid <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= DIV_RST;
        end else if (wr_hs && (wr_reg == 2'd3)) begin
            div_q <= clamp_div(div_wr);
        end
    end

    // ---------------- TX FIFO ----------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr] <= s_axi_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- TX serializer ----------------
    // tx_bitcnt: 0 = start bit, 1..8 = data bits, 9 = stop bit. The divider is
    // re-read at every bit boundary so a DIV write lands on the next bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_busy   <= 1'b0;
            tx        <= 1'b1;
            tx_bitcnt <= 4'd0;
            tx_timer  <= 16'd0;
        end else if (pop) begin
            tx_busy   <= 1'b1;
            tx        <= 1'b0;
            tx_bitcnt <= 4'd0;
            tx_timer  <= div_q - 16'd1;
        end else if (tx_busy) begin
            if (tx_timer == 16'd0) begin
                if (tx_bitcnt == 4'd9) begin
                    tx_busy <= 1'b0;
                end else begin
                    tx        <= tx_shift[0];
                    tx_bitcnt <= tx_bitcnt + 4'd1;
                    tx_timer  <= div_q - 16'd1;
                end
            end else begin
                tx_timer <= tx_timer - 16'd1;
            end
        end
    end

    // Shift register carries the stop bit above the data so the stop bit falls
    // out naturally after the eighth data bit.
    always_ff @(posedge clk) begin
        if (pop) begin
            tx_shift <= {1'b1, fifo_mem[rptr]};
        end else if (tx_busy && (tx_timer == 16'd0) && (tx_bitcnt != 4'd9)) begin
            tx_shift <= {1'b1, tx_shift[8:1]};
        end
    end

    // ---------------- RX synchronizer and deserializer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_prev <= rx_sync[1];
        end
    end

    assign rx_s    = rx_sync[1];
    assign rx_done = (rx_state == RX_STOP) && (rx_timer == 16'd0) && rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state  <= RX_IDLE;
            rx_timer  <= 16'd0;
            rx_bitcnt <= 3'd0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_state <= RX_START;
                        rx_timer <= (div_q >> 1) - 16'd1;
                    end
                end
                RX_START: begin
                    if (rx_timer == 16'd0) begin
                        // A line that is high again at mid start bit was a glitch.
                        if (rx_s) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state  <= RX_DATA;
                            rx_bitcnt <= 3'd0;
                            rx_timer  <= div_q - 16'd1;
                        end
                    end else begin
                        rx_timer <= rx_timer - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_timer == 16'd0) begin
                        rx_bitcnt <= rx_bitcnt + 3'd1;
                        rx_timer  <= div_q - 16'd1;
                        if (rx_bitcnt == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_timer <= rx_timer - 16'd1;
                    end
                end
                default: begin
                    // Stop bit sampled here; a low stop bit is dropped silently.
                    if (rx_timer == 16'd0) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_timer <= rx_timer - 16'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((rx_state == RX_DATA) && (rx_timer == 16'd0)) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
        end
        if (rx_done) begin
            rx_data <= rx_shift;
        end
    end

    // A completing byte outranks a same-cycle RXDATA/STATUS read so that a
    // fresh byte and its overrun indication are never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_done)        rx_valid <= 1'b1;
            else if (rd_rxdata) rx_valid <= 1'b0;
            if (rx_done && rx_valid) rx_overrun <= 1'b1;
            else if (rd_status)      rx_overrun <= 1'b0;
        end
    end

    // ---------------- read channel ----------------
    always_comb begin
        rd_mux = 32'd0;
        case (rd_reg)
            2'd1:    rd_mux = {28'd0, rx_overrun, rx_valid, tx_idle, tx_full};
            2'd2:    rd_mux = {24'd0, rx_data};
            2'd3:    rd_mux = {16'd0, div_q};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate       <= R_IDLE;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= 32'd0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (rd_hs) begin
                        rstate       <= R_DATA;
                        s_axi_rvalid <= 1'b1;
                        s_axi_rdata  <= rd_mux;
                    end
                end
                default: begin
                    if (s_axi_rready) begin
                        rstate       <= R_IDLE;
                        s_axi_rvalid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axilite_uart_slave.sv
// Directed testbench for axilite_uart_slave: register access, TX framing and
// FIFO full behaviour, RX reception/overrun/error cases, and reset mid-frame.
module tb_axilite_uart_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  awaddr, araddr, wstrb;
    logic [31:0] wdata, rdata;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic        tx, rx;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic txlog [0:16383];
    logic [7:0] rxq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < 16384) txlog[cyc] = tx;

    axilite_uart_slave #(.CLK_DIV(868), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .tx(tx), .rx(rx)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full AXI write: returns response, cycle index of the handshake edge, and
    // number of cycles from the handshake edge until bvalid was seen.
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int hs, output int lat);
        bit ok = 0;
        resp = 2'b11; hs = -1; lat = -1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (awready && wready) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wr_handshake: no awready/wready for addr %h", a);
            awvalid = 1'b0; wvalid = 1'b0;
            tick(1);
            return;
        end
        @(posedge clk); #1;
        hs = cyc;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bvalid) begin lat = i; resp = bresp; break; end
            @(posedge clk); #1;
        end
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL wr_bvalid: bvalid never rose for addr %h", a);
        end
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output int lat);
        bit ok = 0;
        d = 32'hDEAD_BEEF; lat = -1;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL rd_handshake: no arready for addr %h", a);
            arvalid = 1'b0;
            tick(1);
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (rvalid) begin lat = i; d = rdata; break; end
            @(posedge clk); #1;
        end
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL rd_rvalid: rvalid never rose for addr %h", a);
        end
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    // Drive one 8N1 frame at 8 clocks per bit.
    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx = 1'b0; tick(8);
        for (int k = 0; k < 8; k++) begin rx = b[k]; tick(8); end
        rx = stop; tick(8);
        rx = 1'b1; tick(6);
    endtask

    // Decode 8N1 frames (8 clocks per bit) from the logged tx line.
    task automatic decode_tx(input int from, input int upto);
        int i = from;
        logic [7:0] b;
        rxq.delete();
        while (i + 80 <= upto) begin
            if (txlog[i] == 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = txlog[i + 4 + 8 * (k + 1)];
                rxq.push_back(b);
                i = i + 80;
            end else begin
                i = i + 1;
            end
        end
    endtask

    logic [31:0] rd;
    logic [1:0]  resp;
    int          hs, lat;

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks++;
        if (tx !== 1'b1 || awready !== 1'b0 || wready !== 1'b0 || arready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: tx=%b awready=%b wready=%b arready=%b, required 1 0 0 0",
                     tx, awready, wready, arready);
        end
        checks++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'd0 || bresp !== 2'd0 || rresp !== 2'd0) begin
            errors++;
            $display("FAIL reset_out: bvalid=%b rvalid=%b rdata=%h bresp=%b rresp=%b, required all 0",
                     bvalid, rvalid, rdata, bresp, rresp);
        end
        rst = 1'b0;
        tick(2);
        axi_read(4'h4, rd, lat);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL reset_status: got %h required 00000002", rd); end
        checks++;
        if (lat !== 0) begin errors++; $display("FAIL read_latency: got %0d required 0", lat); end
        axi_read(4'hC, rd, lat);
        checks++;
        if (rd !== 32'd868) begin errors++; $display("FAIL reset_div: got %0d required 868", rd); end
    endtask

    task automatic test_regs();
        axi_write(4'hC, 32'd2, 4'hF, resp, hs, lat);
        checks++;
        if (lat !== 0 || resp !== 2'b00) begin
            errors++; $display("FAIL div_write: lat=%0d resp=%b, required 0 00", lat, resp);
        end
        axi_read(4'hC, rd, lat);
        checks++;
        if (rd !== 32'd4) begin errors++; $display("FAIL div_clamp: got %0d required 4", rd); end
        axi_write(4'hC, 32'h0001_2345, 4'hF, resp, hs, lat);
        axi_read(4'hC, rd, lat);
        checks++;
        if (rd !== 32'h0000_2345) begin errors++; $display("FAIL div_upper: got %h required 00002345", rd); end
        axi_write(4'h4, 32'hFF, 4'hF, resp, hs, lat);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL status_write_resp: got %b required 00", resp); end
        axi_read(4'h0, rd, lat);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL txdata_read: got %h required 0", rd); end
        axi_write(4'hC, 32'd8, 4'hF, resp, hs, lat);
        axi_read(4'hC, rd, lat);
        checks++;
        if (rd !== 32'd8) begin errors++; $display("FAIL div_set8: got %0d required 8", rd); end
    endtask

    task automatic test_tx_frame();
        logic [9:0] frame = {1'b1, 8'h55, 1'b0};
        bit bad;
        axi_write(4'h0, 32'h55, 4'h1, resp, hs, lat);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL tx_resp: got %b required 00", resp); end
        tick(85);
        checks++;
        if (txlog[hs] !== 1'b1) begin errors++; $display("FAIL tx_pre_start: got %b required 1", txlog[hs]); end
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int j = 1; j <= 8; j++) if (txlog[hs + 8 * b + j] !== frame[b]) bad = 1;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL tx_bit%0d: got %b at first cycle, required %b for 8 cycles",
                         b, txlog[hs + 8 * b + 1], frame[b]);
            end
        end
        axi_read(4'h4, rd, lat);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL tx_done_status: got %h required 2", rd); end
    endtask

    task automatic test_back_to_back();
        int first_hs;
        bit bad = 0;
        axi_write(4'h0, 32'h41, 4'h1, resp, first_hs, lat);
        if (resp !== 2'b00) bad = 1;
        for (int k = 1; k < 5; k++) begin
            axi_write(4'h0, 32'h41 + k, 4'h1, resp, hs, lat);
            if (resp !== 2'b00) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL b2b_resp: a write in 0x41..0x45 got %b, required OKAY", resp); end
        axi_read(4'h4, rd, lat);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL b2b_full: got %h required 1", rd); end
        axi_write(4'h0, 32'h99, 4'h1, resp, hs, lat);
        checks++;
        if (resp !== 2'b10) begin errors++; $display("FAIL b2b_slverr: got %b required 10", resp); end
        tick(460);
        decode_tx(first_hs, cyc);
        checks++;
        if (rxq.size() !== 5) begin errors++; $display("FAIL b2b_count: got %0d frames required 5", rxq.size()); end
        for (int k = 0; k < 5 && k < rxq.size(); k++) begin
            checks++;
            if (rxq[k] !== 8'(8'h41 + k)) begin
                errors++; $display("FAIL b2b_byte%0d: got %h required %h", k, rxq[k], 8'(8'h41 + k));
            end
        end
        axi_read(4'h4, rd, lat);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL b2b_idle: got %h required 2", rd); end
    endtask

    task automatic test_rx_basic();
        send_rx(8'hA3, 1'b1);
        axi_read(4'h4, rd, lat);
        checks++;
        if (rd !== 32'h6) begin errors++; $display("FAIL rx_status: got %h required 6", rd); end
        axi_read(4'h8, rd, lat);
        checks++;
        if (rd !== 32'hA3) begin errors++; $display("FAIL rx_data: got %h required a3", rd); end
        axi_read(4'h4, rd, lat);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL rx_cleared: got %h required 2", rd); end
    endtask

    task automatic test_rx_overrun();
        send_rx(8'h3C, 1'b1);
        send_rx(8'hC5, 1'b1);
        axi_read(4'h4, rd, lat);
        checks++;
        if (rd !== 32'hE) begin errors++; $display("FAIL ovr_status: got %h required e", rd); end
        axi_read(4'h4, rd, lat);
        checks++;
        if (rd !== 32'h6) begin errors++; $display("FAIL ovr_clear: got %h required 6", rd); end
        axi_read(4'h8, rd, lat);
        checks++;
        if (rd !== 32'hC5) begin errors++; $display("FAIL ovr_data: got %h required c5", rd); end
        axi_read(4'h4, rd, lat);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL ovr_final: got %h required 2", rd); end
    endtask

    task automatic test_rx_errors();
        rx = 1'b0; tick(2);
        rx = 1'b1; tick(20);
        axi_read(4'h4, rd, lat);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL rx_glitch: got %h required 2", rd); end
        send_rx(8'h5A, 1'b0);
        tick(4);
        axi_read(4'h4, rd, lat);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL rx_framing: got %h required 2", rd); end
    endtask

    task automatic test_reset_mid_frame();
        int start;
        bit bad = 0;
        axi_write(4'h0, 32'h11, 4'h1, resp, hs, lat);
        axi_write(4'h0, 32'h22, 4'h1, resp, hs, lat);
        axi_write(4'h0, 32'h33, 4'h1, resp, hs, lat);
        tick(12);
        rst = 1'b1;
        tick(1);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b required 1", tx); end
        rst = 1'b0;
        start = cyc;
        tick(100);
        for (int i = start; i < cyc; i++) if (txlog[i] !== 1'b1) bad = 1;
        checks++;
        if (bad) begin errors++; $display("FAIL rst_tx_quiet: tx went low after reset, required 1"); end
        axi_read(4'h4, rd, lat);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL rst_fifo: got %h required 2", rd); end
        axi_read(4'hC, rd, lat);
        checks++;
        if (rd !== 32'd868) begin errors++; $display("FAIL rst_div: got %0d required 868", rd); end
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        awaddr = 4'h0; araddr = 4'h0; wdata = 32'h0; wstrb = 4'h0;
        @(posedge clk); #1;
        test_reset();
        test_regs();
        test_tx_frame();
        test_back_to_back();
        test_rx_basic();
        test_rx_overrun();
        test_rx_errors();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
